// File: rtl/sapho_io_ctrl.sv
// sapho_io_ctrl: I/O port controller between the core bus and peripherals.
// One-word buffers per port, stall generation and round-robin interrupt.
module sapho_io_ctrl #(
  parameter int NUBITS  = 32,
  parameter int NUIOIN  = 2,
  parameter int NUIOOUT = 5,
  parameter int SRCW    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUIOIN-1:0]         proc_req_in,
  output logic [NUBITS-1:0]         proc_io_in,
  input  logic [NUIOOUT-1:0]        proc_out_en,
  input  logic [NUBITS-1:0]         proc_io_out,
  output logic                      proc_stall,
  input  logic                      itr_en,
  output logic                      proc_itr,
  output logic [SRCW-1:0]           itr_src,
  input  logic [NUIOIN*NUBITS-1:0]  in_data,
  input  logic [NUIOIN-1:0]         in_valid,
  output logic [NUIOIN-1:0]         in_ready,
  output logic [NUIOOUT*NUBITS-1:0] out_data,
  output logic [NUIOOUT-1:0]        out_valid,
  input  logic [NUIOOUT-1:0]        out_ready,
  output logic                      err_strobe
);
  localparam int IW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [NUBITS-1:0]  hold [NUIOIN];
  logic [NUIOIN-1:0]  full;
  logic [NUIOIN-1:0]  fresh;
  logic [SRCW-1:0]    ptr;
  logic [0:0]         state;

  logic               rd_multi;
  logic               wr_multi;
  logic               rd_sel;
  logic               wr_sel;
  logic               rd_hit;
  logic               wr_free;
  logic               stall_raw;
  logic               rd_go;
  logic               wr_go;
  logic [NUIOIN-1:0]  cap;
  logic [NUIOIN-1:0]  rd_clr;
  logic [NUIOIN-1:0]  gnt_clr;
  logic [NUIOOUT-1:0] ld;
  logic               gnt_hit;
  logic [SRCW-1:0]    gnt_idx;
  logic               gnt_go;
  logic               gnt_full;
  logic [SRCW-1:0]    ptr_next;

  assign rd_multi = |(proc_req_in & (proc_req_in - NUIOIN'(1)));
  assign wr_multi = |(proc_out_en & (proc_out_en - NUIOOUT'(1)));
  assign rd_sel   = |proc_req_in & ~rd_multi;
  assign wr_sel   = |proc_out_en & ~wr_multi;
  assign rd_hit   = |(proc_req_in & full);
  assign wr_free  = |(proc_out_en & (~out_valid | out_ready));

  // A request that cannot complete holds the core; both sides wait together
  assign stall_raw  = (rd_sel & ~rd_hit) | (wr_sel & ~wr_free);
  assign proc_stall = rst & stall_raw;

  assign rd_go   = rd_sel & rd_hit & ~stall_raw;
  assign wr_go   = wr_sel & wr_free & ~stall_raw;
  assign rd_clr  = rd_go ? proc_req_in : '0;
  assign ld      = wr_go ? proc_out_en : '0;
  assign cap     = in_valid & ~full;
  assign in_ready = ~full;

  assign gnt_go   = (state == S_IDLE) & itr_en & gnt_hit;
  assign gnt_clr  = gnt_go ? (NUIOIN'(1) << gnt_idx) : '0;
  assign gnt_full = |(full & (NUIOIN'(1) << itr_src));
  assign ptr_next = (int'(gnt_idx) == NUIOIN - 1) ? '0
                  : gnt_idx + SRCW'(1);

  // Zero-latency read mux from the selected hold register
  always_comb begin
    proc_io_in = '0;
    for (int i = 0; i < NUIOIN; i++)
      if (rst && rd_sel && proc_req_in[i] && full[i])
        proc_io_in = hold[i];
  end

  // Round-robin search for the first fresh port from ptr upward
  always_comb begin
    int p;
    p       = 0;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int k = NUIOIN - 1; k >= 0; k--) begin
      p = int'(ptr) + k;
      if (p >= NUIOIN) p = p - NUIOIN;
      if (fresh[p[IW-1:0]]) begin
        gnt_hit = 1'b1;
        gnt_idx = SRCW'(p);
      end
    end
  end

  // Input hold registers with full and fresh flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full  <= '0;
      fresh <= '0;
      for (int i = 0; i < NUIOIN; i++) hold[i] <= '0;
    end else begin
      full  <= (full & ~rd_clr) | cap;
      fresh <= (fresh & ~rd_clr & ~gnt_clr) | cap;
      for (int i = 0; i < NUIOIN; i++)
        if (cap[i]) hold[i] <= in_data[i*NUBITS +: NUBITS];
    end
  end

  // Output slots: load overrides drain, error flag is sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= '0;
      out_data   <= '0;
      err_strobe <= 1'b0;
    end else begin
      out_valid  <= (out_valid & ~out_ready) | ld;
      err_strobe <= err_strobe | rd_multi | wr_multi;
      for (int j = 0; j < NUIOOUT; j++)
        if (ld[j]) out_data[j*NUBITS +: NUBITS] <= proc_io_out;
    end
  end

  // Interrupt FSM: one pulse per grant, then wait for the read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      proc_itr <= 1'b0;
      itr_src  <= '0;
      ptr      <= '0;
    end else begin
      proc_itr <= 1'b0;
      unique case (state)
        S_IDLE: if (gnt_go) begin
          proc_itr <= 1'b1;
          itr_src  <= gnt_idx;
          ptr      <= ptr_next;
          state    <= S_WAIT;
        end
        S_WAIT: if (!gnt_full || !itr_en) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sapho_io_ctrl.sv
// tb_sapho_io_ctrl: vector table, random run against a reference model,
// and directed interrupt / strobe-error / async-reset sequences.
module tb_sapho_io_ctrl;
  localparam int NB = 32;
  localparam int NI = 2;
  localparam int NO = 5;
  localparam int SW = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NI-1:0]    proc_req_in;
  logic [NB-1:0]    proc_io_in;
  logic [NO-1:0]    proc_out_en;
  logic [NB-1:0]    proc_io_out;
  logic             proc_stall;
  logic             itr_en;
  logic             proc_itr;
  logic [SW-1:0]    itr_src;
  logic [NI*NB-1:0] in_data;
  logic [NI-1:0]    in_valid;
  logic [NI-1:0]    in_ready;
  logic [NO*NB-1:0] out_data;
  logic [NO-1:0]    out_valid;
  logic [NO-1:0]    out_ready;
  logic             err_strobe;

  sapho_io_ctrl #(
    .NUBITS(NB), .NUIOIN(NI), .NUIOOUT(NO), .SRCW(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .proc_req_in(proc_req_in), .proc_io_in(proc_io_in),
    .proc_out_en(proc_out_en), .proc_io_out(proc_io_out),
    .proc_stall(proc_stall), .itr_en(itr_en),
    .proc_itr(proc_itr), .itr_src(itr_src),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_strobe(err_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] od(input int j);
    return out_data[j*NB +: NB];
  endfunction

  function automatic int idx1(input logic [7:0] v);
    int c = 0;
    int r = -1;
    for (int b = 0; b < 8; b++)
      if (v[b]) begin c++; r = b; end
    return (c == 1) ? r : -1;
  endfunction

  task automatic idle_in();
    proc_req_in = '0; proc_out_en = '0; proc_io_out = '0;
    itr_en = 1'b0; in_data = '0; in_valid = '0; out_ready = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [4:0]  oen;
    logic [31:0] wd;
    logic [1:0]  iv;
    logic [31:0] din;
    logic [4:0]  ordy;
    logic        stall;
    logic [31:0] io;
    logic [4:0]  ov;
    logic [31:0] od2;
    logic [31:0] od0;
    logic [1:0]  rdy;
  } vec_t;

  vec_t tv[17];

  // reference model state
  bit          m_full[NI];
  logic [31:0] m_hold[NI];
  bit          m_new[NI];
  bit          m_ov[NO];
  logic [31:0] m_od[NO];
  bit          m_err;
  bit          m_itr;
  int          m_src;
  int          m_ptr;
  bit          m_wait;

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      m_full[i] = 0; m_hold[i] = '0; m_new[i] = 0;
    end
    for (int j = 0; j < NO; j++) begin
      m_ov[j] = 0; m_od[j] = '0;
    end
    m_err = 0; m_itr = 0; m_src = 0; m_ptr = 0; m_wait = 0;
  endtask

  task automatic model_cycle();
    int ri, wi, g;
    bit rb, wb, st;
    bit ofull[NI];
    logic [31:0] eio;
    logic [4:0] eov;
    logic [1:0] erdy;
    ri = idx1(8'(proc_req_in));
    wi = idx1(8'(proc_out_en));
    rb = (ri >= 0) && !m_full[ri];
    wb = (wi >= 0) && m_ov[wi] && !out_ready[wi];
    st = rb || wb;
    eio = ((ri >= 0) && m_full[ri]) ? m_hold[ri] : 32'd0;
    for (int j = 0; j < NO; j++) eov[j] = m_ov[j];
    for (int i = 0; i < NI; i++) erdy[i] = !m_full[i];
    chk("rnd_stall", 32'(proc_stall), 32'(st));
    chk("rnd_io", proc_io_in, eio);
    chk("rnd_ov", 32'(out_valid), 32'(eov));
    chk("rnd_rdy", 32'(in_ready), 32'(erdy));
    chk("rnd_itr", 32'(proc_itr), 32'(m_itr));
    chk("rnd_src", 32'(itr_src), 32'(m_src));
    chk("rnd_err", 32'(err_strobe), 32'(m_err));
    for (int j = 0; j < NO; j++) chk("rnd_od", od(j), m_od[j]);
    // next state
    for (int i = 0; i < NI; i++) ofull[i] = m_full[i];
    m_itr = 0;
    if (!m_wait) begin
      g = -1;
      if (itr_en)
        for (int k = 0; k < NI; k++)
          if (g < 0 && m_new[(m_ptr + k) % NI]) g = (m_ptr + k) % NI;
      if (g >= 0) begin
        m_itr = 1; m_src = g; m_new[g] = 0;
        m_ptr = (g + 1) % NI; m_wait = 1;
      end
    end else if (!ofull[m_src] || !itr_en) begin
      m_wait = 0;
    end
    if (ri >= 0 && ofull[ri] && !st) begin
      m_full[ri] = 0; m_new[ri] = 0;
    end
    for (int i = 0; i < NI; i++)
      if (in_valid[i] && !ofull[i]) begin
        m_full[i] = 1; m_new[i] = 1;
        m_hold[i] = in_data[i*NB +: NB];
      end
    for (int j = 0; j < NO; j++)
      if (wi == j && !st) begin
        m_ov[j] = 1; m_od[j] = proc_io_out;
      end else if (out_ready[j]) begin
        m_ov[j] = 0;
      end
    if ($countones(proc_req_in) > 1 || $countones(proc_out_en) > 1)
      m_err = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int r, pulses;
    logic [31:0] s0, s1;
    tv[0]  = '{2'b00, 5'b00000, 32'd0,  2'b10, 32'd42, 5'b0,
               1'b0, 32'd0, 5'b0, 32'd0, 32'd0, 2'b11};
    tv[1]  = '{2'b10, 5'b00000, 32'd0,  2'b00, 32'd0, 5'b0,
               1'b0, 32'd42, 5'b0, 32'd0, 32'd0, 2'b01};
    tv[2]  = '{2'b01, 5'b00000, 32'd0,  2'b00, 32'd0, 5'b0,
               1'b1, 32'd0, 5'b0, 32'd0, 32'd0, 2'b11};
    tv[3]  = tv[2];
    tv[4]  = '{2'b01, 5'b00000, 32'd0,  2'b01, 32'hFFFF_FFFB, 5'b0,
               1'b1, 32'd0, 5'b0, 32'd0, 32'd0, 2'b11};
    tv[5]  = '{2'b01, 5'b00000, 32'd0,  2'b00, 32'd0, 5'b0,
               1'b0, 32'hFFFF_FFFB, 5'b0, 32'd0, 32'd0, 2'b10};
    tv[6]  = '{2'b00, 5'b00100, 32'd7,  2'b00, 32'd0, 5'b0,
               1'b0, 32'd0, 5'b0, 32'd0, 32'd0, 2'b11};
    tv[7]  = '{2'b00, 5'b00100, 32'd9,  2'b00, 32'd0, 5'b0,
               1'b1, 32'd0, 5'b00100, 32'd7, 32'd0, 2'b11};
    tv[8]  = tv[7];
    tv[9]  = '{2'b00, 5'b00100, 32'd9,  2'b00, 32'd0, 5'b00100,
               1'b0, 32'd0, 5'b00100, 32'd7, 32'd0, 2'b11};
    tv[10] = '{2'b00, 5'b00000, 32'd0,  2'b00, 32'd0, 5'b0,
               1'b0, 32'd0, 5'b00100, 32'd9, 32'd0, 2'b11};
    tv[11] = '{2'b00, 5'b00000, 32'd0,  2'b00, 32'd0, 5'b00100,
               1'b0, 32'd0, 5'b00100, 32'd9, 32'd0, 2'b11};
    tv[12] = '{2'b00, 5'b00000, 32'd0,  2'b00, 32'd0, 5'b0,
               1'b0, 32'd0, 5'b0, 32'd9, 32'd0, 2'b11};
    tv[13] = '{2'b10, 5'b00001, 32'h55, 2'b00, 32'd0, 5'b0,
               1'b1, 32'd0, 5'b0, 32'd9, 32'd0, 2'b11};
    tv[14] = '{2'b10, 5'b00001, 32'h55, 2'b10, 32'h77, 5'b0,
               1'b1, 32'd0, 5'b0, 32'd9, 32'd0, 2'b11};
    tv[15] = '{2'b10, 5'b00001, 32'h55, 2'b00, 32'd0, 5'b0,
               1'b0, 32'h77, 5'b0, 32'd9, 32'd0, 2'b01};
    tv[16] = '{2'b00, 5'b00000, 32'd0,  2'b00, 32'd0, 5'b0,
               1'b0, 32'd0, 5'b00001, 32'd9, 32'h55, 2'b11};

    do_reset();
    #1;
    chk("rst_stall", 32'(proc_stall), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_strobe), 32'd0);
    chk("rst_itr", 32'(proc_itr), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd3);
    tick();

    for (int t = 0; t < 17; t++) begin
      proc_req_in = tv[t].req;
      proc_out_en = tv[t].oen;
      proc_io_out = tv[t].wd;
      in_valid    = tv[t].iv;
      in_data     = {tv[t].din, tv[t].din};
      out_ready   = tv[t].ordy;
      #1;
      chk($sformatf("tv%0d_stall", t), 32'(proc_stall), 32'(tv[t].stall));
      chk($sformatf("tv%0d_io", t), proc_io_in, tv[t].io);
      chk($sformatf("tv%0d_ov", t), 32'(out_valid), 32'(tv[t].ov));
      chk($sformatf("tv%0d_od2", t), od(2), tv[t].od2);
      chk($sformatf("tv%0d_od0", t), od(0), tv[t].od0);
      chk($sformatf("tv%0d_rdy", t), 32'(in_ready), 32'(tv[t].rdy));
      tick();
    end

    // interrupt round robin
    do_reset();
    itr_en = 1'b1;
    in_valid = 2'b11;
    in_data = {32'd11, 32'd10};
    tick();
    in_valid = 2'b00;
    #1;
    chk("itr_early", 32'(proc_itr), 32'd0);
    tick();
    pulses = 0; s0 = '1; s1 = '1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (proc_itr) begin
        if (pulses == 0) begin
          s0 = 32'(itr_src);
          proc_req_in = 2'b01;
        end else if (pulses == 1) begin
          s1 = 32'(itr_src);
        end
        pulses++;
      end else begin
        proc_req_in = 2'b00;
      end
      tick();
    end
    chk("itr_pulses", pulses, 32'd2);
    chk("itr_src0", s0, 32'd0);
    chk("itr_src1", s1, 32'd1);

    // strobe error, then async reset mid-stall
    do_reset();
    proc_out_en = 5'b00011;
    proc_io_out = 32'd123;
    #1;
    chk("err_nostall", 32'(proc_stall), 32'd0);
    tick();
    proc_out_en = '0;
    #1;
    chk("err_set", 32'(err_strobe), 32'd1);
    chk("err_nocommit", 32'(out_valid), 32'd0);
    tick();
    tick();
    chk("err_sticky", 32'(err_strobe), 32'd1);
    proc_out_en = 5'b01000;
    proc_io_out = 32'd1;
    tick();
    proc_io_out = 32'd2;
    #1;
    chk("midstall", 32'(proc_stall), 32'd1);
    chk("midstall_ov", 32'(out_valid), 32'h8);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_stall", 32'(proc_stall), 32'd0);
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_od3", od(3), 32'd0);
    chk("arst_err", 32'(err_strobe), 32'd0);
    chk("arst_io", proc_io_in, 32'd0);
    chk("arst_src", 32'(itr_src), 32'd0);
    idle_in();
    tick();
    rst = 1'b1;

    // randomized run against the model
    do_reset();
    model_clear();
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 15);
      proc_req_in = (r < 8) ? 2'b00 : (r < 11) ? 2'b01 :
                    (r < 14) ? 2'b10 : (r == 14) ? 2'b11 : 2'b00;
      r = $urandom_range(0, 31);
      proc_out_en = (r < 14) ? 5'b0 :
                    (r < 30) ? 5'(1 << (r % 5)) : 5'($urandom);
      proc_io_out = $urandom;
      in_valid    = 2'($urandom);
      in_data     = {$urandom, $urandom};
      out_ready   = 5'($urandom);
      itr_en      = ($urandom_range(0, 7) != 0);
      #1;
      model_cycle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
